lut_bootstrap_loader: RTL and testbench

//  Upstream write-side driver for a 4Kx8 asynchronous LUT SRAM (write on falling N_WE, read when N_OE low).

---
 rtl/lut_bootstrap_loader.sv | 187 ++++++++++++++++++
 tb/tb_lut_bootstrap_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_bootstrap_loader.sv
// Streams bytes into an asynchronous LUT SRAM at addresses 0..DEPTH-1 with setup/strobe/hold timing on N_WE.
// When idle, the system read path (SYS_ADDR, SYS_N_OE) passes through to the LUT.
module lut_bootstrap_loader #(
    parameter int unsigned ADDR_W        = 12,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_BYTE,
    input  logic [ADDR_W-1:0] SYS_ADDR,
    input  logic              SYS_N_OE,
    output logic [ADDR_W-1:0] LUT_ADDR,
    output logic [DATA_W-1:0] LUT_DATA,
    output logic              LUT_N_WE,
    output logic              LUT_N_OE,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [DATA_W-1:0] CHECKSUM
);

    localparam int unsigned PH_W = 8;
    localparam logic [PH_W-1:0]   SETUP_LAST  = PH_W'(SETUP_CYCLES - 1);
    localparam logic [PH_W-1:0]   STROBE_LAST = PH_W'(STROBE_CYCLES - 1);
    localparam logic [PH_W-1:0]   HOLD_LAST   = PH_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST   = '1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_BYTE = 3'd1,
        S_SETUP     = 3'd2,
        S_STROBE    = 3'd3,
        S_HOLD      = 3'd4,
        S_FINISH    = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   csum_q, csum_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                abort_pend_q, abort_pend_d;
    logic                n_we_q, n_we_d;
    logic                busy_q, busy_d;
    logic                in_ready_q, in_ready_d;

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            ph_q         <= '0;
            cnt_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            csum_q       <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            abort_pend_q <= 1'b0;
            n_we_q       <= 1'b1;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            csum_q       <= csum_d;
            done_q       <= done_d;
            err_q        <= err_d;
            abort_pend_q <= abort_pend_d;
            n_we_q       <= n_we_d;
            busy_q       <= busy_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // Next-state logic; registered outputs are derived from the next state
    always_comb begin
        state_d      = state_q;
        ph_d         = ph_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        data_d       = data_q;
        csum_d       = csum_q;
        done_d       = done_q;
        err_d        = err_q;
        abort_pend_d = abort_pend_q;

        case (state_q)
            S_IDLE, S_FINISH: begin
                if (START) begin
                    state_d      = S_WAIT_BYTE;
                    cnt_d        = '0;
                    csum_d       = '0;
                    done_d       = 1'b0;
                    err_d        = 1'b0;
                    abort_pend_d = 1'b0;
                end
            end
            S_WAIT_BYTE: begin
                if (ABORT) begin
                    state_d = S_FINISH;
                    err_d   = 1'b1;
                end else if (IN_VALID && in_ready_q) begin
                    addr_d  = cnt_q;
                    data_d  = IN_BYTE;
                    csum_d  = csum_q + IN_BYTE;
                    ph_d    = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                // Abort here cancels the write before N_WE ever falls
                if (ABORT) begin
                    state_d = S_FINISH;
                    err_d   = 1'b1;
                end else if (ph_q == SETUP_LAST) begin
                    ph_d    = '0;
                    state_d = S_STROBE;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_STROBE: begin
                if (ABORT) begin
                    abort_pend_d = 1'b1;
                end
                if (ph_q == STROBE_LAST) begin
                    ph_d    = '0;
                    state_d = S_HOLD;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_HOLD: begin
                if (ph_q == HOLD_LAST) begin
                    if (abort_pend_q || ABORT) begin
                        state_d = S_FINISH;
                        err_d   = 1'b1;
                    end else if (cnt_q == ADDR_LAST) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                        state_d = S_WAIT_BYTE;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                    if (ABORT) begin
                        abort_pend_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d     = (state_d == S_WAIT_BYTE) || (state_d == S_SETUP) ||
                     (state_d == S_STROBE) || (state_d == S_HOLD);
        in_ready_d = (state_d == S_WAIT_BYTE);
        n_we_d     = (state_d != S_STROBE);
    end

    // Read path passes through only when no load is running, so N_OE and N_WE are never both low
    assign LUT_ADDR = busy_q ? addr_q : SYS_ADDR;
    assign LUT_N_OE = busy_q | SYS_N_OE;
    assign LUT_DATA = data_q;
    assign LUT_N_WE = n_we_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign ERR      = err_q;
    assign IN_READY = in_ready_q;
    assign CHECKSUM = csum_q;

endmodule

// File: tb/tb_lut_bootstrap_loader.sv
// Self-checking bench for lut_bootstrap_loader with ADDR_W=3 and a sampled async-SRAM model.
module tb_lut_bootstrap_loader;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              CLK = 1'b0;
    logic              RST;
    logic              START;
    logic              ABORT;
    logic              IN_VALID;
    logic              IN_READY;
    logic [DATA_W-1:0] IN_BYTE;
    logic [ADDR_W-1:0] SYS_ADDR;
    logic              SYS_N_OE;
    logic [ADDR_W-1:0] LUT_ADDR;
    logic [DATA_W-1:0] LUT_DATA;
    logic              LUT_N_WE;
    logic              LUT_N_OE;
    logic              BUSY;
    logic              DONE;
    logic              ERR;
    logic [DATA_W-1:0] CHECKSUM;

    lut_bootstrap_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .SETUP_CYCLES(1), .STROBE_CYCLES(2), .HOLD_CYCLES(1)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_BYTE(IN_BYTE),
        .SYS_ADDR(SYS_ADDR), .SYS_N_OE(SYS_N_OE),
        .LUT_ADDR(LUT_ADDR), .LUT_DATA(LUT_DATA), .LUT_N_WE(LUT_N_WE), .LUT_N_OE(LUT_N_OE),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .CHECKSUM(CHECKSUM)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int inv_err  = 0;
    int gap_low  = 0;

    // SRAM model sampled on the falling clock edge: a write happens where N_WE was high and is now low
    logic [DATA_W-1:0] mem      [DEPTH];
    int                fall_cnt [DEPTH];
    int                low_cnt  [DEPTH];
    int                fall_cyc [DEPTH];
    int                cyc      = 0;
    logic              prev_we  = 1'b1;
    logic              clr_model = 1'b0;

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (clr_model) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i]      <= '0;
                fall_cnt[i] <= 0;
                low_cnt[i]  <= 0;
                fall_cyc[i] <= 0;
            end
        end else begin
            if (prev_we && !LUT_N_WE) begin
                mem[LUT_ADDR]      <= LUT_DATA;
                fall_cnt[LUT_ADDR] <= fall_cnt[LUT_ADDR] + 1;
                fall_cyc[LUT_ADDR] <= cyc;
            end
            if (!LUT_N_WE) low_cnt[LUT_ADDR] <= low_cnt[LUT_ADDR] + 1;
        end
        prev_we <= LUT_N_WE;
        assert (LUT_N_OE || LUT_N_WE) else begin
            $display("FAIL oe_we_invariant: N_OE=%0b N_WE=%0b required at least one high", LUT_N_OE, LUT_N_WE);
            inv_err <= inv_err + 1;
        end
    end

    typedef struct {
        logic [ADDR_W-1:0] sys_addr;
        logic              sys_n_oe;
        logic [ADDR_W-1:0] exp_addr;
        logic              exp_n_oe;
    } pt_vec_t;

    pt_vec_t pt_vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        clr_model = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        clr_model = 1'b0;
        @(negedge CLK);
    endtask

    task automatic pulse_start();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    // Waits for IN_READY, idles for gap cycles, then presents one byte for exactly one handshake
    task automatic send_byte(input logic [DATA_W-1:0] b, input int gap);
        int n = 0;
        while (!IN_READY && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!IN_READY) begin
            chk("ready_timeout", 32'(IN_READY), 32'd1);
            return;
        end
        repeat (gap) begin
            @(negedge CLK);
            if (!LUT_N_WE) gap_low++;
        end
        IN_VALID = 1'b1;
        IN_BYTE  = b;
        @(posedge CLK);
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk("idle_timeout", 32'(BUSY), 32'd0);
    endtask

    initial begin
        logic [DATA_W-1:0] s;
        logic [DATA_W-1:0] b;
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] s;
        pt_vecs[0] = '{3'd5, 1'b0, 3'd5, 1'b0};
        pt_vecs[1] = '{3'd2, 1'b1, 3'd2, 1'b1};
        pt_vecs[2] = '{3'd7, 1'b0, 3'd7, 1'b0};
        pt_vecs[3] = '{3'd0, 1'b1, 3'd0, 1'b1};

        RST = 1'b1; START = 1'b0; ABORT = 1'b0; IN_VALID = 1'b0; IN_BYTE = '0;
        SYS_ADDR = '0; SYS_N_OE = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_n_we", 32'(LUT_N_WE), 32'd1);
        chk("rst_n_oe", 32'(LUT_N_OE), 32'd1);
        chk("rst_ready", 32'(IN_READY), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_csum", 32'(CHECKSUM), 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Idle passthrough table
        for (int i = 0; i < 4; i++) begin
            SYS_ADDR = pt_vecs[i].sys_addr;
            SYS_N_OE = pt_vecs[i].sys_n_oe;
            #1;
            chk($sformatf("pt_addr[%0d]", i), 32'(LUT_ADDR), 32'(pt_vecs[i].exp_addr));
            chk($sformatf("pt_n_oe[%0d]", i), 32'(LUT_N_OE), 32'(pt_vecs[i].exp_n_oe));
            chk($sformatf("pt_n_we[%0d]", i), 32'(LUT_N_WE), 32'd1);
            @(negedge CLK);
        end
        SYS_N_OE = 1'b1;
        SYS_ADDR = '0;

        // Full back-to-back load with a START pulse ignored mid-load
        clear_model();
        gap_low = 0;
        pulse_start();
        s = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            send_byte(DATA_W'(8'h10 + i), 0);
            s = s + DATA_W'(8'h10 + i);
            if (i == 3) pulse_start();
        end
        wait_idle();
        @(negedge CLK);
        for (int i = 0; i < int'(DEPTH); i++) begin
            chk($sformatf("t1_mem[%0d]", i), 32'(mem[i]), 32'(8'h10 + i));
            chk($sformatf("t1_falls[%0d]", i), 32'(fall_cnt[i]), 32'd1);
            chk($sformatf("t1_lowcyc[%0d]", i), 32'(low_cnt[i]), 32'd2);
            if (i > 0) chk($sformatf("t1_period[%0d]", i), 32'(fall_cyc[i] - fall_cyc[i-1]), 32'd5);
        end
        chk("t1_done", 32'(DONE), 32'd1);
        chk("t1_err", 32'(ERR), 32'd0);
        chk("t1_csum", 32'(CHECKSUM), 32'(s));
        chk("t1_ready_after", 32'(IN_READY), 32'd0);
        chk("t1_last_data", 32'(LUT_DATA), 32'h17);

        // Backpressure with random idle gaps
        clear_model();
        gap_low = 0;
        pulse_start();
        for (int i = 0; i < int'(DEPTH); i++) send_byte(DATA_W'(8'h10 + i), int'($urandom_range(0, 7)));
        wait_idle();
        @(negedge CLK);
        for (int i = 0; i < int'(DEPTH); i++) begin
            chk($sformatf("t2_mem[%0d]", i), 32'(mem[i]), 32'(8'h10 + i));
            chk($sformatf("t2_falls[%0d]", i), 32'(fall_cnt[i]), 32'd1);
        end
        chk("t2_gap_we_low", 32'(gap_low), 32'd0);
        chk("t2_done", 32'(DONE), 32'd1);
        chk("t2_csum", 32'(CHECKSUM), 32'(s));

        // Abort during the strobe of address 3
        clear_model();
        pulse_start();
        s = '0;
        for (int i = 0; i < 4; i++) begin
            send_byte(DATA_W'(8'hA0 + i), 0);
            s = s + DATA_W'(8'hA0 + i);
        end
        @(negedge CLK);
        chk("t3_in_strobe", 32'(LUT_N_WE), 32'd0);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        wait_idle();
        @(negedge CLK);
        chk("t3_mem3", 32'(mem[3]), 32'hA3);
        chk("t3_lowcyc3", 32'(low_cnt[3]), 32'd2);
        chk("t3_falls3", 32'(fall_cnt[3]), 32'd1);
        for (int i = 4; i < int'(DEPTH); i++) chk($sformatf("t3_untouched[%0d]", i), 32'(fall_cnt[i]), 32'd0);
        chk("t3_err", 32'(ERR), 32'd1);
        chk("t3_done", 32'(DONE), 32'd0);
        chk("t3_csum", 32'(CHECKSUM), 32'(s));

        // Abort during the setup of address 2
        clear_model();
        pulse_start();
        for (int i = 0; i < 3; i++) send_byte(DATA_W'(8'h50 + i), 0);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        wait_idle();
        @(negedge CLK);
        chk("t4_falls1", 32'(fall_cnt[1]), 32'd1);
        chk("t4_falls2", 32'(fall_cnt[2]), 32'd0);
        chk("t4_err", 32'(ERR), 32'd1);
        chk("t4_done", 32'(DONE), 32'd0);
        chk("t4_csum", 32'(CHECKSUM), 32'hF3);

        // START and ABORT together from FINISH: START wins; then ABORT while waiting for a byte
        START = 1'b1;
        ABORT = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        ABORT = 1'b0;
        chk("sa_busy", 32'(BUSY), 32'd1);
        chk("sa_err", 32'(ERR), 32'd0);
        chk("sa_ready", 32'(IN_READY), 32'd1);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        chk("wb_abort_err", 32'(ERR), 32'd1);
        chk("wb_abort_busy", 32'(BUSY), 32'd0);
        chk("wb_abort_done", 32'(DONE), 32'd0);

        // Reset during a strobe, then a clean reload from address 0
        pulse_start();
        send_byte(8'h61, 0);
        send_byte(8'h62, 0);
        @(negedge CLK);
        chk("t5_in_strobe", 32'(LUT_N_WE), 32'd0);
        RST = 1'b1;
        @(negedge CLK);
        chk("t5_n_we", 32'(LUT_N_WE), 32'd1);
        chk("t5_n_oe", 32'(LUT_N_OE), 32'd1);
        chk("t5_busy", 32'(BUSY), 32'd0);
        chk("t5_ready", 32'(IN_READY), 32'd0);
        chk("t5_done", 32'(DONE), 32'd0);
        chk("t5_err", 32'(ERR), 32'd0);
        chk("t5_csum", 32'(CHECKSUM), 32'd0);
        RST = 1'b0;
        clear_model();
        pulse_start();
        for (int i = 0; i < int'(DEPTH); i++) send_byte(DATA_W'(8'h30 + i), 0);
        wait_idle();
        @(negedge CLK);
        for (int i = 0; i < int'(DEPTH); i++) begin
            chk($sformatf("t5_mem[%0d]", i), 32'(mem[i]), 32'(8'h30 + i));
            chk($sformatf("t5_falls[%0d]", i), 32'(fall_cnt[i]), 32'd1);
        end
        chk("t5_reload_done", 32'(DONE), 32'd1);

        chk("oe_we_invariant_total", 32'(inv_err), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
